// File: rtl/drop_scan_ctrl.sv
// Landing-search engine: probes one drop offset per cycle for the latched piece and
// arbitrates hard-drop (priority) and shadow-refresh requests onto that single probe path.
module drop_scan_ctrl #(
   parameter int unsigned WIDTH  = 10,
   parameter int unsigned HEIGHT = 20,
   parameter int unsigned DW     = 5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [9:0]              ctrlX1,
   input  logic [9:0]              ctrlX2,
   input  logic [9:0]              ctrlX3,
   input  logic [9:0]              ctrlX4,
   input  logic [9:0]              ctrlY1,
   input  logic [9:0]              ctrlY2,
   input  logic [9:0]              ctrlY3,
   input  logic [9:0]              ctrlY4,
   input  logic [0:WIDTH*HEIGHT-1] boardMemory,
   input  logic                    hd_req,
   input  logic                    sh_req,
   output logic                    busy,
   output logic                    hd_done,
   output logic                    sh_done,
   output logic [DW-1:0]           drop_dist,
   output logic [9:0]              shadowX1,
   output logic [9:0]              shadowX2,
   output logic [9:0]              shadowX3,
   output logic [9:0]              shadowX4,
   output logic [9:0]              shadowY1,
   output logic [9:0]              shadowY2,
   output logic [9:0]              shadowY3,
   output logic [9:0]              shadowY4
);

   localparam int unsigned IW        = $clog2(WIDTH * HEIGHT);
   localparam logic [9:0]  WidthLim  = 10'(WIDTH);
   localparam logic [9:0]  HeightLim = 10'(HEIGHT);

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

   state_e          r_state;
   state_e          w_state_next;

   logic [9:0]      w_cx [4];
   logic [9:0]      w_cy [4];
   logic [9:0]      r_x  [4];
   logic [9:0]      r_y  [4];
   logic [9:0]      r_sx [4];
   logic [9:0]      r_sy [4];
   logic [9:0]      r_k;
   logic [DW-1:0]   r_drop;
   logic            r_owner_sh;
   logic            r_hd_pend;
   logic            r_sh_pend;

   logic            w_hd_any;
   logic            w_sh_any;
   logic            w_accept;
   logic            w_accept_hd;
   logic            w_accept_sh;
   logic            w_invalid;
   logic            w_hit;

   assign w_cx[0] = ctrlX1;
   assign w_cx[1] = ctrlX2;
   assign w_cx[2] = ctrlX3;
   assign w_cx[3] = ctrlX4;
   assign w_cy[0] = ctrlY1;
   assign w_cy[1] = ctrlY2;
   assign w_cy[2] = ctrlY3;
   assign w_cy[3] = ctrlY4;

   // Pending set seen by the arbiter includes this cycle's pulses
   assign w_hd_any    = r_hd_pend | hd_req;
   assign w_sh_any    = r_sh_pend | sh_req;
   assign w_accept_hd = (r_state == StIdle) & w_hd_any;
   assign w_accept_sh = (r_state == StIdle) & ~w_hd_any & w_sh_any;
   assign w_accept    = w_accept_hd | w_accept_sh;

   // Probe offset r_k for all four latched cells
   always_comb begin
      logic [9:0]    row;
      logic          self_hit;
      logic [IW-1:0] idx;
      row       = '0;
      self_hit  = 1'b0;
      idx       = '0;
      w_invalid = 1'b0;
      w_hit     = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if ((r_x[i] >= WidthLim) || (r_y[i] >= HeightLim)) begin
            w_invalid = 1'b1;
         end
      end
      for (int i = 0; i < 4; i++) begin
         row      = r_y[i] + r_k;
         self_hit = 1'b0;
         for (int j = 0; j < 4; j++) begin
            if ((r_x[j] == r_x[i]) && (r_y[j] == row)) begin
               self_hit = 1'b1;
            end
         end
         // Floor check first so the board index is only formed when in range
         if (row >= HeightLim) begin
            w_hit = 1'b1;
         end else if (!w_invalid) begin
            idx = IW'(32'(row) * WIDTH + 32'(r_x[i]));
            if (boardMemory[idx] && !self_hit) begin
               w_hit = 1'b1;
            end
         end
      end
      if (w_invalid) begin
         w_hit = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (w_accept) w_state_next = StScan;
         StScan:  if (w_hit) w_state_next = StDone;
         StDone:  w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_comb begin
      busy    = (r_state != StIdle);
      hd_done = (r_state == StDone) & ~r_owner_sh;
      sh_done = (r_state == StDone) &  r_owner_sh;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_hd_pend  <= 1'b0;
         r_sh_pend  <= 1'b0;
         r_owner_sh <= 1'b0;
         r_k        <= '0;
         r_drop     <= '0;
         for (int i = 0; i < 4; i++) begin
            r_x[i]  <= '0;
            r_y[i]  <= '0;
            r_sx[i] <= '0;
            r_sy[i] <= '0;
         end
      end else begin
         r_hd_pend <= w_hd_any & ~w_accept_hd;
         r_sh_pend <= w_sh_any & ~w_accept_sh;
         if (w_accept) begin
            r_owner_sh <= w_accept_sh;
            r_k        <= 10'd1;
            for (int i = 0; i < 4; i++) begin
               r_x[i] <= w_cx[i];
               r_y[i] <= w_cy[i];
            end
         end
         if (r_state == StScan) begin
            if (w_hit) begin
               // An invalid piece always hits at r_k == 1, giving a distance of 0
               r_drop <= DW'(r_k - 10'd1);
               if (r_owner_sh) begin
                  for (int i = 0; i < 4; i++) begin
                     r_sx[i] <= r_x[i];
                     r_sy[i] <= r_y[i] + r_k - 10'd1;
                  end
               end
            end else begin
               r_k <= r_k + 10'd1;
            end
         end
      end
   end

   assign drop_dist = r_drop;
   assign shadowX1  = r_sx[0];
   assign shadowX2  = r_sx[1];
   assign shadowX3  = r_sx[2];
   assign shadowX4  = r_sx[3];
   assign shadowY1  = r_sy[0];
   assign shadowY2  = r_sy[1];
   assign shadowY3  = r_sy[2];
   assign shadowY4  = r_sy[3];

endmodule
